data_store_buffer: RTL and testbench
====================================

Name: data_store_buffer

Overview:
- Circular FIFO between the data-cache controllers and the external memory interface.
- Accepts word-granular write-backs of dirty lines from the load-side cache controller and byte/half/word stores from the store unit.
- Drains entries to external memory one at a time over a request/acknowledge handshake.
- Provides a combinational address lookup so loads can forward the youngest buffered word, or stall on a partial-width conflict.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- XLEN, 32, address width.
- PORT_WIDTH, 32, data word width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- wb_push_i  in  1  write-back push from the load-side cache controller
- wb_address_i  in  XLEN  write-back word address
- wb_data_i  in  PORT_WIDTH  write-back data, always full word
- st_push_i  in  1  store-unit push
- st_address_i  in  XLEN  store address
- st_data_i  in  PORT_WIDTH  store data, LSB-aligned
- st_width_i  in  2  store width: BYTE, HALF or WORD
- st_accept_o  out  1  store-unit push accepted this cycle
- full_o  out  1  no free entry
- empty_o  out  1  no valid entry
- port_idle_o  out  1  write port free this cycle (no push in progress)
- lookup_address_i  in  XLEN  load address to search
- address_match_o  out  1  youngest matching entry is WORD width; forwarding valid
- match_data_o  out  PORT_WIDTH  data of that entry
- conflict_o  out  1  youngest matching entry is BYTE/HALF; load must wait
- mem_request_o  out  1  drain request to external memory
- mem_address_o  out  XLEN  drain address
- mem_data_o  out  PORT_WIDTH  drain data
- mem_width_o  out  2  drain width
- mem_ack_i  in  1  external memory accepted the current drain

Behaviour:
- Reset (async): head = tail = count = 0; all entries invalid; drain FSM in IDLE.
  - Output values during reset: full_o=0, empty_o=1, port_idle_o=1, st_accept_o=0, mem_request_o=0, mem_* =0, address_match_o=0, conflict_o=0, match_data_o=0.
  - Reset mid-drain drops mem_request_o immediately; buffered contents are lost.
- Single write port; one push per cycle.
  - Write-back has priority over the store unit.
  - st_accept_o = st_push_i & !wb_push_i & !full_o.
  - A push while full_o=1 is ignored, even if a pop happens in the same cycle.
  - full_o and empty_o decode the registered count only.
- Push writes the entry at tail on the clock edge; tail increments modulo DEPTH.
- port_idle_o = !(wb_push_i | st_push_i).
- Lookup (combinational):
  - Compare lookup_address_i[XLEN-1:2] against all valid entries.
  - Select the youngest match, i.e. nearest to tail going backwards.
  - WORD width -> address_match_o=1 and match_data_o = entry data.
  - BYTE/HALF width -> conflict_o=1 and address_match_o=0.
  - No match -> all three lookup outputs 0.
  - A pushed entry becomes visible to lookup the cycle after its push.
- Drain FSM:
  - IDLE: if !empty_o, go to REQUEST and register the head entry onto mem_*.
  - REQUEST: mem_request_o=1; mem_* held stable until mem_ack_i.
    - On ack: pop the head (head+1 mod DEPTH, entry invalidated, count-1) and return to IDLE.
    - Minimum of one idle cycle between consecutive requests.
  - Push and pop in the same cycle leave count unchanged.
  - The popped entry is excluded from lookup from the next cycle onward.
- Pointer wrap: head and tail are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- mem_ack_i outside REQUEST is ignored.

Decomposition:
- Shared data memory package holds:
  - store_width_t enum {BYTE, HALF, WORD};
  - store_buffer_entry_t struct {address, data, width};
  - the STORE_BUFFER_DEPTH constant.
- Sub-module store_buffer_match: combinational youngest-match priority search over the valid vector plus head/tail pointers. Outputs match, conflict and the selected index.

Test Plan:
- Reset, then 8 WORD store pushes to 0x100..0x11C with mem_ack_i=0 -> full_o=1 after the 8th; a 9th push gives st_accept_o=0 and count stays 8.
- wb_push_i and st_push_i in the same cycle, buffer empty -> only the wb entry is stored; st_accept_o=0; port_idle_o=0.
- Push WORD 0x200/0xAAAA then WORD 0x200/0xBBBB; lookup 0x200 -> address_match_o=1, match_data_o=0xBBBB.
- Push BYTE 0x301/0x7F; lookup 0x300 -> conflict_o=1, address_match_o=0.
- Push 3 entries; hold mem_ack_i=0 for 5 cycles, then pulse it -> mem_* constant while waiting; one pop per ack; empty_o=1 after the third ack.
- Assert rst_n_i low while mem_request_o=1 with 4 entries queued -> mem_request_o falls immediately; empty_o=1 and full_o=0 after release.

Source files
------------

// File: rtl/data_store_buffer_pkg.sv
// Shared data-memory types for the store buffer: entry layout, store width
// encoding and the drain FSM states.
package data_store_buffer_pkg;

  localparam int STORE_BUFFER_DEPTH = 8;
  localparam int SB_XLEN            = 32;
  localparam int SB_PORT_WIDTH      = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } store_width_t;

  typedef struct packed {
    logic [SB_XLEN-1:0]       address;
    logic [SB_PORT_WIDTH-1:0] data;
    store_width_t             width;
  } store_buffer_entry_t;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_REQUEST
  } drain_state_t;

endpackage

// File: rtl/data_store_buffer_if.sv
// Drain bus between the store buffer (master) and external memory (slave).
interface data_store_buffer_if #(
  parameter int XLEN       = 32,
  parameter int PORT_WIDTH = 32
);
  logic                  request;
  logic [XLEN-1:0]       address;
  logic [PORT_WIDTH-1:0] data;
  logic [1:0]            width;
  logic                  ack;

  modport master (output request, address, data, width, input ack);
  modport slave  (input request, address, data, width, output ack);
endinterface

// File: rtl/data_store_buffer_match.sv
// Youngest-match priority search: walks backwards from tail and reports the
// newest valid entry whose word address matches the lookup.
module store_buffer_match #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] addr_eq,
  input  logic [DEPTH-1:0] is_word,
  input  logic [PTR_W-1:0] tail,
  output logic             match,
  output logic             conflict,
  output logic [PTR_W-1:0] index
);

  logic found;
  logic [PTR_W-1:0] idx;

  // Scan oldest-to-youngest so the youngest hit is the last one assigned.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    found = 1'b0;
    index = '0;
    idx   = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = tail - PTR_W'(i);
      if (valid[idx] && addr_eq[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
    match    = found &  is_word[index];
    conflict = found & ~is_word[index];
  end

endmodule

// File: rtl/data_store_buffer.sv
// Circular store buffer between the data-cache controllers and external
// memory: single write port, youngest-word forwarding lookup, one-at-a-time drain.
module data_store_buffer
  import data_store_buffer_pkg::*;
#(
  parameter int DEPTH      = STORE_BUFFER_DEPTH,
  parameter int XLEN       = SB_XLEN,
  parameter int PORT_WIDTH = SB_PORT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_push_i,
  input  logic [XLEN-1:0]       wb_address_i,
  input  logic [PORT_WIDTH-1:0] wb_data_i,
  input  logic                  st_push_i,
  input  logic [XLEN-1:0]       st_address_i,
  input  logic [PORT_WIDTH-1:0] st_data_i,
  input  logic [1:0]            st_width_i,
  output logic                  st_accept_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  port_idle_o,
  input  logic [XLEN-1:0]       lookup_address_i,
  output logic                  address_match_o,
  output logic [PORT_WIDTH-1:0] match_data_o,
  output logic                  conflict_o,
  data_store_buffer_if.master   mem
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_buffer_entry_t entries [DEPTH];
  store_buffer_entry_t new_entry;
  logic [DEPTH-1:0]    valid;
  logic [DEPTH-1:0]    addr_eq;
  logic [DEPTH-1:0]    is_word;
  logic [PTR_W-1:0]    head, tail, sel;
  logic [CNT_W-1:0]    count;
  logic                push, pop, load_mem;
  drain_state_t        state, next_state;

  assign full_o      = (count == CNT_W'(DEPTH));
  assign empty_o     = (count == '0);
  assign push        = (wb_push_i | st_push_i) & ~full_o;
  // Reset is folded in so the handshake reads idle while the buffer is held in reset.
  assign st_accept_o = rst_n_i & st_push_i & ~wb_push_i & ~full_o;
  assign port_idle_o = ~rst_n_i | ~(wb_push_i | st_push_i);

  // Write-back wins the single write port and is always a full word.
  always_comb begin
    if (wb_push_i) new_entry = '{address: wb_address_i, data: wb_data_i, width: WORD};
    else           new_entry = '{address: st_address_i, data: st_data_i,
                                 width: store_width_t'(st_width_i)};
  end

  // Pointer, count and valid-bit bookkeeping for push and pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written at tail on a push.
  // NOTE: the entry array has no reset; valid bits alone decide what is visible.
  always_ff @(posedge clk_i) begin
    if (push) entries[tail] <= new_entry;
  end

  // Per-entry word-address compare and width flag feeding the priority search.
  always_comb begin
    addr_eq = '0;
    is_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_eq[i] = (entries[i].address[XLEN-1:2] == lookup_address_i[XLEN-1:2]);
      is_word[i] = (entries[i].width == WORD);
    end
  end

  store_buffer_match #(.DEPTH(DEPTH)) u_match (
    .valid    (valid),
    .addr_eq  (addr_eq),
    .is_word  (is_word),
    .tail     (tail),
    .match    (address_match_o),
    .conflict (conflict_o),
    .index    (sel)
  );

  assign match_data_o = address_match_o ? entries[sel].data : '0;

  // Drain FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= DRAIN_IDLE;
    else          state <= next_state;
  end

  // Drain FSM next state: load head when idle, pop on ack.
  always_comb begin
    next_state = state;
    load_mem   = 1'b0;
    pop        = 1'b0;
    case (state)
      DRAIN_IDLE: begin
        if (!empty_o) begin
          next_state = DRAIN_REQUEST;
          load_mem   = 1'b1;
        end
      end
      DRAIN_REQUEST: begin
        if (mem.ack) begin
          next_state = DRAIN_IDLE;
          pop        = 1'b1;
        end
      end
      default: next_state = DRAIN_IDLE;
    endcase
  end

  assign mem.request = (state == DRAIN_REQUEST);

  // Drain bus registers, held stable for the whole request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem.address <= '0;
      mem.data    <= '0;
      mem.width   <= '0;
    end else if (load_mem) begin
      mem.address <= entries[head].address;
      mem.data    <= entries[head].data;
      mem.width   <= entries[head].width;
    end
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Self-checking bench for data_store_buffer: scoreboard of pushed entries
// compared against drained memory requests, plus direct flag/lookup checks.
module tb_data_store_buffer;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  localparam int         DEPTH  = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_push, st_push;
  logic [31:0] wb_address, wb_data, st_address, st_data, lookup_address;
  logic [1:0]  st_width;
  logic        st_accept, full, empty, port_idle, address_match, conflict;
  logic [31:0] match_data;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  data_store_buffer_if #(.XLEN(32), .PORT_WIDTH(32)) mem_if ();

  data_store_buffer dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .wb_push_i        (wb_push),
    .wb_address_i     (wb_address),
    .wb_data_i        (wb_data),
    .st_push_i        (st_push),
    .st_address_i     (st_address),
    .st_data_i        (st_data),
    .st_width_i       (st_width),
    .st_accept_o      (st_accept),
    .full_o           (full),
    .empty_o          (empty),
    .port_idle_o      (port_idle),
    .lookup_address_i (lookup_address),
    .address_match_o  (address_match),
    .match_data_o     (match_data),
    .conflict_o       (conflict),
    .mem              (mem_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    bit   acc;
    exp_t e;
    acc        = (sb.size() < DEPTH);
    st_push    = 1'b1;
    st_address = a;
    st_data    = d;
    st_width   = w;
    #1;
    check("st_accept", st_accept, acc);
    check("port_busy", port_idle, 1'b0);
    tick();
    st_push = 1'b0;
    if (acc) begin
      e.addr = a; e.data = d; e.width = w;
      sb.push_back(e);
    end
    check("full_flag", full, sb.size() == DEPTH);
    check("empty_flag", empty, sb.size() == 0);
  endtask

  task automatic lookup(input string tag, input logic [31:0] a, input logic m,
                        input logic c, input logic [31:0] d);
    lookup_address = a;
    #1;
    check({tag, "_match"}, address_match, m);
    check({tag, "_conflict"}, conflict, c);
    check({tag, "_data"}, match_data, d);
  endtask

  // Waits for a request, compares it with the oldest scoreboard entry,
  // holds off the ack for wait_cycles checking stability, then acks once.
  task automatic drain_one(input int wait_cycles);
    exp_t e;
    for (int k = 0; k < 20 && !mem_if.request; k++) tick();
    if (!mem_if.request) begin
      check("req_timeout", mem_if.request, 1'b1);
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_request", mem_if.request, 1'b0);
      return;
    end
    e = sb.pop_front();
    check("mem_address", mem_if.address, e.addr);
    check("mem_data", mem_if.data, e.data);
    check("mem_width", mem_if.width, e.width);
    for (int k = 0; k < wait_cycles; k++) begin
      tick();
      check("hold_request", mem_if.request, 1'b1);
      check("hold_address", mem_if.address, e.addr);
      check("hold_data", mem_if.data, e.data);
      check("hold_width", mem_if.width, e.width);
    end
    mem_if.ack = 1'b1;
    tick();
    mem_if.ack = 1'b0;
    check("idle_after_ack", mem_if.request, 1'b0);
    check("empty_after_pop", empty, sb.size() == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    wb_push = 1'b0; st_push = 1'b0;
    wb_address = '0; wb_data = '0;
    st_address = '0; st_data = '0; st_width = W_WORD;
    lookup_address = 32'hFFFF_FFF0;
    mem_if.ack = 1'b0;
    #12;
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_port_idle", port_idle, 1'b1);
    check("rst_st_accept", st_accept, 1'b0);
    check("rst_request", mem_if.request, 1'b0);
    check("rst_mem_address", mem_if.address, 32'h0);
    check("rst_match", address_match, 1'b0);
    check("rst_conflict", conflict, 1'b0);
    check("rst_match_data", match_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // Fill to full, then a rejected ninth push.
    for (int i = 0; i < DEPTH; i++)
      push_store(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), W_WORD);
    check("full_after_8", full, 1'b1);
    push_store(32'h120, 32'hDEAD, W_WORD);
    tick();
    check("still_full", full, 1'b1);
    check("head_on_bus", mem_if.address, 32'h100);
    lookup("lk_11c", 32'h11C, 1'b1, 1'b0, 32'h1007);
    lookup("lk_120", 32'h120, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) drain_one(0);
    lookup("lk_popped", 32'h100, 1'b0, 1'b0, 32'h0);

    // Simultaneous write-back and store: write-back wins.
    wb_push = 1'b1; wb_address = 32'h500; wb_data = 32'hCAFE_0001;
    st_push = 1'b1; st_address = 32'h600; st_data = 32'h1; st_width = W_WORD;
    #1;
    check("both_st_accept", st_accept, 1'b0);
    check("both_port_idle", port_idle, 1'b0);
    tick();
    wb_push = 1'b0; st_push = 1'b0;
    sb.push_back('{addr: 32'h500, data: 32'hCAFE_0001, width: W_WORD});
    lookup("lk_wb", 32'h500, 1'b1, 1'b0, 32'hCAFE_0001);
    lookup("lk_st_dropped", 32'h600, 1'b0, 1'b0, 32'h0);
    drain_one(0);
    check("port_idle_quiet", port_idle, 1'b1);

    // Youngest of two same-address words is forwarded; visibility next cycle.
    push_store(32'h200, 32'hAAAA, W_WORD);
    lookup_address = 32'h200;
    st_push = 1'b1; st_address = 32'h200; st_data = 32'hBBBB; st_width = W_WORD;
    #1;
    check("vis_old_data", match_data, 32'hAAAA);
    tick();
    st_push = 1'b0;
    sb.push_back('{addr: 32'h200, data: 32'hBBBB, width: W_WORD});
    lookup("lk_youngest", 32'h203, 1'b1, 1'b0, 32'hBBBB);
    drain_one(0);
    drain_one(0);

    // Partial-width conflict, then a younger word masks it.
    push_store(32'h301, 32'h7F, W_BYTE);
    lookup("lk_byte", 32'h300, 1'b0, 1'b1, 32'h0);
    push_store(32'h302, 32'h1234, W_HALF);
    lookup("lk_half", 32'h300, 1'b0, 1'b1, 32'h0);
    push_store(32'h300, 32'h5555, W_WORD);
    lookup("lk_word_over", 32'h301, 1'b1, 1'b0, 32'h5555);
    drain_one(0);
    drain_one(1);
    drain_one(0);

    // Held-off acknowledge with stability checks.
    for (int i = 0; i < 3; i++) push_store(32'h700 + 32'(4 * i), 32'h7000 + 32'(i), W_WORD);
    for (int i = 0; i < 3; i++) drain_one(5);
    check("empty_after_three", empty, 1'b1);

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) push_store(32'h800 + 32'(4 * i), 32'h8000 + 32'(i), W_WORD);
    for (int k = 0; k < 20 && !mem_if.request; k++) tick();
    check("pre_rst_request", mem_if.request, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_drop_request", mem_if.request, 1'b0);
    check("rst_drop_empty", empty, 1'b1);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_empty", empty, 1'b1);
    check("post_rst_full", full, 1'b0);
    lookup("post_rst_lookup", 32'h800, 1'b0, 1'b0, 32'h0);
    tick();
    check("post_rst_no_request", mem_if.request, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
